reimu_shot_sched: RTL and testbench

Player-shot scheduler. Owns a fixed pool of shot slots and spawns a shot at the player position when fire is held and a slot is free, with a tick-based cooldown between shots. It advances all live shots upward and retires them at the screen top or on a hit report. It sits between the input/player-position logic and the renderer and collision blocks, and replaces per-shot free-running movers.

---
 rtl/reimu_shot_sched_pkg.sv | 25 ++
 rtl/reimu_shot_sched_if.sv | 31 +++
 rtl/reimu_shot_slot.sv | 63 ++++++
 rtl/reimu_shot_sched.sv | 120 ++++++++++++
 tb/tb_reimu_shot_sched.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/reimu_shot_sched_pkg.sv
// Shared types and helpers for the player-shot scheduler.
package reimu_shot_sched_pkg;

    localparam int COORD_W = 10;
    localparam int SLOT_W  = 3;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [0:0] {
        ST_READY = 1'b0,
        ST_COOL  = 1'b1
    } state_e;

    // Saturating subtraction: clamps at zero instead of wrapping.
    function automatic coord_t sat_sub(input coord_t a, input coord_t b);
        coord_t r;
        if (a < b) begin
            r = {COORD_W{1'b0}};
        end else begin
            r = a - b;
        end
        return r;
    endfunction

endpackage

// File: rtl/reimu_shot_sched_if.sv
// Bus between the shot scheduler and its input, renderer and collision neighbours.
interface reimu_shot_sched_if
    import reimu_shot_sched_pkg::*;
#(
    parameter int NSLOT = 4
) ();

    logic                     tick;
    logic                     fire;
    coord_t                   reimux;
    coord_t                   reimuy;
    logic                     hit_valid;
    logic [SLOT_W-1:0]        hit_slot;
    logic [NSLOT-1:0]         shot_active;
    logic [COORD_W*NSLOT-1:0] shot_x;
    logic [COORD_W*NSLOT-1:0] shot_y;
    logic                     spawned;
    logic                     drop;
    logic                     ready;

    modport master (
        output tick, fire, reimux, reimuy, hit_valid, hit_slot,
        input  shot_active, shot_x, shot_y, spawned, drop, ready
    );

    modport slave (
        input  tick, fire, reimux, reimuy, hit_valid, hit_slot,
        output shot_active, shot_x, shot_y, spawned, drop, ready
    );

endinterface

// File: rtl/reimu_shot_slot.sv
// One shot slot: live flag plus position, updated by spawn, hit and movement.
module reimu_shot_slot
    import reimu_shot_sched_pkg::*;
#(
    parameter int STEP = 2
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   spawn_i,
    input  coord_t spawn_x_i,
    input  coord_t spawn_y_i,
    input  logic   tick_i,
    input  logic   hit_i,
    output logic   active_o,
    output coord_t x_o,
    output coord_t y_o
);

    logic   active_q, active_d;
    coord_t x_q, x_d;
    coord_t y_q, y_d;

    // Next state: spawn only lands on a free slot and hits only count on a live
    // one, so the branches never compete; a hit suppresses that tick's move.
    always_comb begin
        active_d = active_q;
        x_d      = x_q;
        y_d      = y_q;
        if (spawn_i) begin
            active_d = 1'b1;
            x_d      = spawn_x_i;
            y_d      = spawn_y_i;
        end else if (active_q && hit_i) begin
            active_d = 1'b0;
        end else if (active_q && tick_i) begin
            if (y_q <= COORD_W'(STEP)) begin
                active_d = 1'b0;
            end else begin
                y_d = y_q - COORD_W'(STEP);
            end
        end else begin
            active_d = active_q;
        end
    end

    // Slot registers; reset kills the shot and clears its position.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q <= 1'b0;
            x_q      <= {COORD_W{1'b0}};
            y_q      <= {COORD_W{1'b0}};
        end else begin
            active_q <= active_d;
            x_q      <= x_d;
            y_q      <= y_d;
        end
    end

    assign active_o = active_q;
    assign x_o      = x_q;
    assign y_o      = y_q;

endmodule

// File: rtl/reimu_shot_sched.sv
// Player-shot scheduler: spawn FSM with tick cooldown over a pool of shot slots.
module reimu_shot_sched
    import reimu_shot_sched_pkg::*;
#(
    parameter int NSLOT     = 4,
    parameter int COOLDOWN  = 8,
    parameter int STEP      = 2,
    parameter int SPAWN_OFS = 16
) (
    input  logic               clk_22,
    input  logic               rst,
    reimu_shot_sched_if.slave  bus
);

    localparam int CNT_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             spawned_q;
    logic             drop_q;
    logic             ready_q;

    logic [NSLOT-1:0] active_s;
    logic [NSLOT-1:0] free_s;
    logic [NSLOT-1:0] lowest_s;
    logic [NSLOT-1:0] spawn_vec_s;
    logic             any_free_s;
    logic             fire_ok_s;
    coord_t           spawn_y_s;
    coord_t           x_s [NSLOT];
    coord_t           y_s [NSLOT];

    // Free mask comes from the registered live flags, so a slot retired this
    // cycle only becomes a spawn candidate next cycle.
    assign free_s    = ~active_s;
    assign fire_ok_s = (state_q == ST_READY) && bus.fire;
    assign spawn_y_s = sat_sub(bus.reimuy, COORD_W'(SPAWN_OFS));

    // Lowest-index free slot as a one-hot vector.
    always_comb begin
        lowest_s   = {NSLOT{1'b0}};
        any_free_s = 1'b0;
        for (int i = 0; i < NSLOT; i++) begin
            if (free_s[i] && !any_free_s) begin
                lowest_s[i] = 1'b1;
                any_free_s  = 1'b1;
            end else begin
                lowest_s[i] = 1'b0;
            end
        end
    end

    assign spawn_vec_s = (fire_ok_s && any_free_s) ? lowest_s : {NSLOT{1'b0}};

    // Spawn/cooldown FSM with registered pulse and ready outputs.
    always_ff @(posedge clk_22 or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_READY;
            cnt_q     <= {CNT_W{1'b0}};
            spawned_q <= 1'b0;
            drop_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            spawned_q <= 1'b0;
            drop_q    <= 1'b0;
            case (state_q)
                ST_READY: begin
                    if (fire_ok_s && any_free_s) begin
                        spawned_q <= 1'b1;
                        cnt_q     <= CNT_W'(COOLDOWN - 1);
                        state_q   <= ST_COOL;
                        ready_q   <= 1'b0;
                    end else if (fire_ok_s) begin
                        drop_q <= 1'b1;
                    end
                end
                ST_COOL: begin
                    if (bus.tick) begin
                        if (cnt_q != {CNT_W{1'b0}}) begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end else begin
                            state_q <= ST_READY;
                            ready_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_READY;
                    cnt_q   <= {CNT_W{1'b0}};
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NSLOT; g++) begin : g_slot
        reimu_shot_slot #(
            .STEP (STEP)
        ) u_slot (
            .clk_i     (clk_22),
            .rst_ni    (rst),
            .spawn_i   (spawn_vec_s[g]),
            .spawn_x_i (bus.reimux),
            .spawn_y_i (spawn_y_s),
            .tick_i    (bus.tick),
            .hit_i     (bus.hit_valid && (bus.hit_slot == SLOT_W'(g))),
            .active_o  (active_s[g]),
            .x_o       (x_s[g]),
            .y_o       (y_s[g])
        );
        assign bus.shot_x[COORD_W*g +: COORD_W] = x_s[g];
        assign bus.shot_y[COORD_W*g +: COORD_W] = y_s[g];
    end

    assign bus.shot_active = active_s;
    assign bus.spawned     = spawned_q;
    assign bus.drop        = drop_q;
    assign bus.ready       = ready_q;

endmodule

// File: tb/tb_reimu_shot_sched.sv
// Self-checking bench for reimu_shot_sched: vector table, corner sequences, random vs model.
module tb_reimu_shot_sched;

    localparam int NSLOT     = 4;
    localparam int COOLDOWN  = 8;
    localparam int STEP      = 2;
    localparam int SPAWN_OFS = 16;

    logic clk_22;
    logic rst;

    reimu_shot_sched_if #(.NSLOT(NSLOT)) bus ();

    reimu_shot_sched #(
        .NSLOT     (NSLOT),
        .COOLDOWN  (COOLDOWN),
        .STEP      (STEP),
        .SPAWN_OFS (SPAWN_OFS)
    ) dut (
        .clk_22 (clk_22),
        .rst    (rst),
        .bus    (bus)
    );

    initial clk_22 = 1'b0;
    always #5 clk_22 = ~clk_22;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: live flags and positions per slot, plus the number of
    // ticks still owed before the next spawn may happen (0 = ready).
    int m_act [NSLOT];
    int m_x   [NSLOT];
    int m_y   [NSLOT];
    int m_left;
    int m_spawned;
    int m_drop;

    typedef struct {
        int fire; int tick; int rx; int ry; int hv; int hs;
        int e_act; int e_sp; int e_dr; int e_rdy; int e_x0; int e_y0;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int k = 0; k < NSLOT; k++) begin
            m_act[k] = 0; m_x[k] = 0; m_y[k] = 0;
        end
        m_left = 0; m_spawned = 0; m_drop = 0;
    endtask

    task automatic model_step(input int f, input int t, input int rx, input int ry,
                              input int hv, input int hs);
        int fr;
        fr = -1;
        for (int k = 0; k < NSLOT; k++) if (fr < 0 && m_act[k] == 0) fr = k;
        m_spawned = 0;
        m_drop    = 0;
        for (int k = 0; k < NSLOT; k++) begin
            if (m_act[k] != 0) begin
                if (hv != 0 && hs == k) m_act[k] = 0;
                else if (t != 0) begin
                    if (m_y[k] <= STEP) m_act[k] = 0;
                    else m_y[k] = m_y[k] - STEP;
                end
            end
        end
        if (m_left == 0) begin
            if (f != 0) begin
                if (fr >= 0) begin
                    m_act[fr] = 1;
                    m_x[fr]   = rx;
                    m_y[fr]   = (ry < SPAWN_OFS) ? 0 : ry - SPAWN_OFS;
                    m_spawned = 1;
                    m_left    = COOLDOWN;
                end else begin
                    m_drop = 1;
                end
            end
        end else if (t != 0) begin
            m_left = m_left - 1;
        end
    endtask

    task automatic model_check();
        logic [63:0] ea, ex, ey;
        ea = 64'd0; ex = 64'd0; ey = 64'd0;
        for (int k = 0; k < NSLOT; k++) begin
            ea[k]         = (m_act[k] != 0);
            ex[10*k +: 10] = 10'(m_x[k]);
            ey[10*k +: 10] = 10'(m_y[k]);
        end
        chk("active",  64'(bus.shot_active), ea);
        chk("shot_x",  64'(bus.shot_x), ex);
        chk("shot_y",  64'(bus.shot_y), ey);
        chk("spawned", 64'(bus.spawned), 64'(m_spawned));
        chk("drop",    64'(bus.drop), 64'(m_drop));
        chk("ready",   64'(bus.ready), 64'(m_left == 0));
    endtask

    task automatic drive(input int f, input int t, input int rx, input int ry,
                         input int hv, input int hs);
        bus.fire      = 1'(f);
        bus.tick      = 1'(t);
        bus.reimux    = 10'(rx);
        bus.reimuy    = 10'(ry);
        bus.hit_valid = 1'(hv);
        bus.hit_slot  = 3'(hs);
    endtask

    task automatic cycle(input int f, input int t, input int rx, input int ry,
                         input int hv, input int hs);
        drive(f, t, rx, ry, hv, hs);
        model_step(f, t, rx, ry, hv, hs);
        @(posedge clk_22);
        #1;
        model_check();
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        model_reset();
        @(posedge clk_22);
        @(posedge clk_22);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int nsp;
        int fd;
        logic [9:0] y2;

        //        f t  rx  ry hv hs  act sp dr rdy x0  y0
        tbl[0]  = '{1, 0, 100, 200, 0, 0, 1, 1, 0, 0, 100, 184};
        tbl[1]  = '{1, 0, 100, 200, 0, 0, 1, 0, 0, 0, 100, 184};
        tbl[2]  = '{0, 1, 100, 200, 0, 0, 1, 0, 0, 0, 100, 182};
        tbl[3]  = '{0, 1, 100, 200, 1, 0, 0, 0, 0, 0, 100, 182};
        tbl[4]  = '{0, 1, 100, 200, 1, 5, 0, 0, 0, 0, 100, 182};
        tbl[5]  = '{0, 1, 100, 200, 0, 0, 0, 0, 0, 0, 100, 182};
        tbl[6]  = '{0, 1, 100, 200, 0, 0, 0, 0, 0, 0, 100, 182};
        tbl[7]  = '{0, 1, 100, 200, 0, 0, 0, 0, 0, 0, 100, 182};
        tbl[8]  = '{0, 1, 100, 200, 0, 0, 0, 0, 0, 0, 100, 182};
        tbl[9]  = '{0, 1, 100, 200, 0, 0, 0, 0, 0, 1, 100, 182};
        tbl[10] = '{1, 1,   7,  10, 0, 0, 1, 1, 0, 0,   7,   0};
        tbl[11] = '{0, 1,   7,  10, 0, 0, 0, 0, 0, 0,   7,   0};
        tbl[12] = '{1, 0,   7,  10, 0, 0, 0, 0, 0, 0,   7,   0};

        // Reset held with fire asserted: nothing may spawn.
        rst = 1'b0;
        drive(1, 0, 100, 200, 0, 0);
        @(posedge clk_22);
        @(posedge clk_22);
        #1;
        chk("rst_active",  64'(bus.shot_active), 64'd0);
        chk("rst_x",       64'(bus.shot_x), 64'd0);
        chk("rst_y",       64'(bus.shot_y), 64'd0);
        chk("rst_spawned", 64'(bus.spawned), 64'd0);
        chk("rst_drop",    64'(bus.drop), 64'd0);
        chk("rst_ready",   64'(bus.ready), 64'd1);
        rst = 1'b1;

        // Table of hand-computed vectors.
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].fire, tbl[i].tick, tbl[i].rx, tbl[i].ry, tbl[i].hv, tbl[i].hs);
            @(posedge clk_22);
            #1;
            chk($sformatf("tbl%0d_active", i),  64'(bus.shot_active), 64'(tbl[i].e_act));
            chk($sformatf("tbl%0d_spawned", i), 64'(bus.spawned), 64'(tbl[i].e_sp));
            chk($sformatf("tbl%0d_drop", i),    64'(bus.drop), 64'(tbl[i].e_dr));
            chk($sformatf("tbl%0d_ready", i),   64'(bus.ready), 64'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_x0", i),      64'(bus.shot_x[9:0]), 64'(tbl[i].e_x0));
            chk($sformatf("tbl%0d_y0", i),      64'(bus.shot_y[9:0]), 64'(tbl[i].e_y0));
        end

        // Fire held, tick every cycle: spawns every 9 cycles, drop once pool is full.
        do_reset();
        nsp = 0;
        fd  = -1;
        for (int c = 0; c < 38; c++) begin
            cycle(1, 1, c * 3, 500, 0, 0);
            if (bus.spawned) nsp++;
            if (bus.drop && fd < 0) fd = c;
        end
        chk("seq_spawn_count", 64'(nsp), 64'd4);
        chk("seq_first_drop",  64'(fd), 64'd36);
        chk("seq_pool_full",   64'(bus.shot_active), 64'hF);

        // Hit on slot 2 coincident with a tick: cleared, y not moved.
        y2 = bus.shot_y[29:20];
        cycle(0, 1, 0, 0, 1, 2);
        chk("hit_clear",  64'(bus.shot_active[2]), 64'd0);
        chk("hit_y_hold", 64'(bus.shot_y[29:20]), 64'(y2));
        cycle(0, 0, 0, 0, 1, 5);
        chk("hit_oob", 64'(bus.shot_active), 64'hB);

        // Full flight from y=184: live at y=2 after tick 91, retired on tick 92.
        do_reset();
        cycle(1, 0, 100, 200, 0, 0);
        for (int t = 1; t <= 92; t++) begin
            cycle(0, 1, 0, 0, 0, 0);
            if (t == 91) begin
                chk("flight_t91_active", 64'(bus.shot_active[0]), 64'd1);
                chk("flight_t91_y",      64'(bus.shot_y[9:0]), 64'd2);
            end
            if (t == 92) begin
                chk("flight_t92_active", 64'(bus.shot_active[0]), 64'd0);
                chk("flight_t92_y",      64'(bus.shot_y[9:0]), 64'd2);
            end
        end

        // Asynchronous reset between edges with three live shots while cooling.
        do_reset();
        for (int c = 0; c < 20; c++) cycle(1, 1, 50 + c, 500, 0, 0);
        chk("arst_pre_active", 64'(bus.shot_active), 64'h7);
        chk("arst_pre_ready",  64'(bus.ready), 64'd0);
        @(posedge clk_22);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_active", 64'(bus.shot_active), 64'd0);
        chk("arst_ready",  64'(bus.ready), 64'd1);
        chk("arst_x",      64'(bus.shot_x), 64'd0);
        chk("arst_y",      64'(bus.shot_y), 64'd0);

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int f, t, rx, ry, hv, hs;
            f  = ($urandom_range(0, 1) == 1) ? 1 : 0;
            t  = ($urandom_range(0, 2) == 0) ? 1 : 0;
            rx = $urandom_range(0, 1023);
            ry = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 1023);
            hv = ($urandom_range(0, 3) == 0) ? 1 : 0;
            hs = $urandom_range(0, 7);
            cycle(f, t, rx, ry, hv, hs);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
